// File: rtl/native_mem_responder_if.sv
// Native back-end memory bus between a cache back-end (master) and a memory responder (slave).
// A request is held valid until a one-cycle ready pulse completes it.
interface native_mem_responder_if #(
  parameter int BE_ADDR_W = 32,
  parameter int BE_DATA_W = 32
);
  localparam int BE_NBYTES = BE_DATA_W / 8;

  logic                 mem_valid;
  logic [BE_ADDR_W-1:0] mem_addr;
  logic [BE_DATA_W-1:0] mem_wdata;
  logic [BE_NBYTES-1:0] mem_wstrb;
  logic [BE_DATA_W-1:0] mem_rdata;
  logic                 mem_ready;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/native_mem_responder.sv
// Word-organised RAM responder for the native back-end bus with programmable read/write latency.
// Define NATIVE_MEM_STATS_EN to build the completed-read/write counters (rd_cnt/wr_cnt).
module native_mem_responder #(
  parameter int BE_ADDR_W  = 32,
  parameter int BE_DATA_W  = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int RD_LAT     = 2,
  parameter int WR_LAT     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  native_mem_responder_if.slave  bus,
  output logic [31:0]            rd_cnt,
  output logic [31:0]            wr_cnt
);
  localparam int BE_NBYTES = BE_DATA_W / 8;
  localparam int BE_BYTE_W = $clog2(BE_NBYTES);
  localparam int MAX_LAT   = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W     = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] RD_CNT0 = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] WR_CNT0 = CNT_W'((WR_LAT > 1) ? WR_LAT - 2 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [MEM_ADDR_W-1:0] idx_q;
  logic [BE_DATA_W-1:0]  wdata_q;
  logic [BE_NBYTES-1:0]  wstrb_q;
  logic [BE_DATA_W-1:0]  rdata_q;
  logic                  accept;

  logic [BE_DATA_W-1:0]  ram [2**MEM_ADDR_W];

  logic [MEM_ADDR_W-1:0] req_idx;
  logic                  req_is_wr;
  logic                  wr_q;
  logic [MEM_ADDR_W-1:0] rd_idx;
  logic                  rd_is_wr;
  logic                  unused_addr;

  // Low byte-offset bits and bits above the word index are ignored, so addresses wrap.
  assign req_idx     = bus.mem_addr[BE_BYTE_W +: MEM_ADDR_W];
  assign req_is_wr   = |bus.mem_wstrb;
  assign wr_q        = |wstrb_q;
  assign unused_addr = ^bus.mem_addr;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    rd_idx   = idx_q;
    rd_is_wr = wr_q;
    case (state_q)
      IDLE: begin
        rd_idx   = req_idx;
        rd_is_wr = req_is_wr;
        if (bus.mem_valid) begin
          accept = 1'b1;
          if (req_is_wr ? (WR_LAT == 1) : (RD_LAT == 1)) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = req_is_wr ? WR_CNT0 : RD_CNT0;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= req_idx;
        wdata_q <= bus.mem_wdata;
        wstrb_q <= bus.mem_wstrb;
      end
      // Read data is captured on entry to RESP so it is valid throughout the ready cycle.
      if (state_d == RESP && !rd_is_wr) rdata_q <= ram[rd_idx];
    end
  end

  // NOTE: the RAM array has no reset; contents survive reset and only the control path is cleared.
  always_ff @(posedge clk) begin
    if (state_q == RESP && wr_q) begin
      for (int i = 0; i < BE_NBYTES; i++) begin
        if (wstrb_q[i]) ram[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.mem_ready = (state_q == RESP);
  assign bus.mem_rdata = rdata_q;

`ifdef NATIVE_MEM_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (state_q == RESP) begin
      if (wr_q) wr_cnt <= wr_cnt + 32'd1;
      else      rd_cnt <= rd_cnt + 32'd1;
    end
  end
`else
  assign rd_cnt = '0;
  assign wr_cnt = '0;
`endif

endmodule

// File: tb/tb_native_mem_responder.sv
// Self-checking bench for native_mem_responder: directed table, line refill, random traffic
// against a word-array reference model, and reset-abort sequences.
module tb_native_mem_responder;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;
  localparam int DEPTH  = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rd_cnt, wr_cnt;

  native_mem_responder_if #(.BE_ADDR_W(32), .BE_DATA_W(32)) bus_if ();

  native_mem_responder #(
    .BE_ADDR_W(32), .BE_DATA_W(32), .MEM_ADDR_W(10), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus_if.slave), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: plain word array, last read value, completion counts.
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_last;
  int unsigned model_rd, model_wr;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_apply(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, output logic [31:0] exp);
    int idx;
    idx = int'((addr / 4) % DEPTH);
    if (wstrb == 4'h0) begin
      exp        = model_mem[idx];
      model_last = exp;
      model_rd++;
    end else begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      exp = model_last;
      model_wr++;
    end
  endtask

  task automatic model_reset();
    model_last = 32'h0;
    model_rd   = 0;
    model_wr   = 0;
  endtask

  task automatic check_cnts(input string name);
`ifdef NATIVE_MEM_STATS_EN
    check({name, " rd_cnt"}, rd_cnt, model_rd);
    check({name, " wr_cnt"}, wr_cnt, model_wr);
`else
    check({name, " rd_cnt"}, rd_cnt, 32'h0);
    check({name, " wr_cnt"}, wr_cnt, 32'h0);
`endif
  endtask

  // Called just after an edge (IDLE, or RESP when chaining). Returns latency in edges.
  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                      input bit hold, output logic [31:0] got, output int lat);
    bus_if.mem_valid = 1'b1;
    bus_if.mem_addr  = addr;
    bus_if.mem_wdata = wdata;
    bus_if.mem_wstrb = wstrb;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus_if.mem_ready && lat < 20);
    got = bus_if.mem_rdata;
    if (!hold) begin
      bus_if.mem_valid = 1'b0;
      @(posedge clk);
      #1;
      check("ready single pulse", {31'h0, bus_if.mem_ready}, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] got, exp, a, d;
    logic [3:0]  s;
    int          lat;

    reset            = 1'b1;
    bus_if.mem_valid = 1'b0;
    bus_if.mem_addr  = '0;
    bus_if.mem_wdata = '0;
    bus_if.mem_wstrb = '0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

    vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, WR_LAT};
    vecs[1] = '{32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, RD_LAT};
    vecs[2] = '{32'h0000_0010, 32'h0000_AA00, 4'h2, 32'hDEAD_BEEF, WR_LAT};
    vecs[3] = '{32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_AAEF, RD_LAT};
    vecs[4] = '{32'h0000_0000, 32'h0000_0055, 4'hF, 32'hDEAD_AAEF, WR_LAT};
    vecs[5] = '{32'h0000_1000, 32'h0,         4'h0, 32'h0000_0055, RD_LAT};
    vecs[6] = '{32'h0000_0013, 32'h0,         4'h0, 32'hDEAD_AAEF, RD_LAT};
    vecs[7] = '{32'h0000_0014, 32'hAABB_CCDD, 4'hF, 32'hDEAD_AAEF, WR_LAT};
    vecs[8] = '{32'h0000_0014, 32'h1122_3344, 4'h9, 32'hDEAD_AAEF, WR_LAT};
    vecs[9] = '{32'hFFFF_F016, 32'h0,         4'h0, 32'h11BB_CC44, RD_LAT};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset mem_ready", {31'h0, bus_if.mem_ready}, 32'h0);
    check("reset mem_rdata", bus_if.mem_rdata, 32'h0);
    check_cnts("reset");

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      xfer(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 1'b0, got, lat);
      model_apply(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, exp);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d rdata", i), got, vecs[i].exp_rdata);
    end
    check_cnts("table");

    // Line refill: preload, then 8 reads with valid held high throughout.
    for (int i = 0; i < 8; i++) begin
      a = 32'h100 + 32'(4 * i);
      d = $urandom;
      xfer(a, d, 4'hF, 1'b0, got, lat);
      model_apply(a, d, 4'hF, exp);
    end
    for (int i = 0; i < 8; i++) begin
      a = 32'h100 + 32'(4 * i);
      xfer(a, 32'h0, 4'h0, (i < 7), got, lat);
      model_apply(a, 32'h0, 4'h0, exp);
      check($sformatf("refill%0d spacing", i), 32'(lat), 32'((i == 0) ? RD_LAT : RD_LAT + 1));
      check($sformatf("refill%0d rdata", i), got, exp);
    end
    check_cnts("refill");

    // Random traffic over a 16-word window with random offset and upper address bits.
    for (int k = 0; k < 16; k++) begin
      a = (32'h80 + 32'(k)) << 2;
      d = $urandom;
      xfer(a, d, 4'hF, 1'b0, got, lat);
      model_apply(a, d, 4'hF, exp);
    end
    for (int i = 0; i < 150; i++) begin
      a = ($urandom & 32'hFFFF_F003) | ((32'h80 + 32'($urandom_range(15, 0))) << 2);
      d = $urandom;
      s = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
      xfer(a, d, s, 1'b0, got, lat);
      model_apply(a, d, s, exp);
      check($sformatf("rand%0d latency", i), 32'(lat), 32'((s == 4'h0) ? RD_LAT : WR_LAT));
      check($sformatf("rand%0d rdata", i), got, exp);
    end
    check_cnts("random");

    // Reset abort of a write: reset lands in the RESP cycle, before the committing edge.
    xfer(32'h20, 32'h1, 4'hF, 1'b0, got, lat);
    model_apply(32'h20, 32'h1, 4'hF, exp);
    bus_if.mem_valid = 1'b1;
    bus_if.mem_addr  = 32'h20;
    bus_if.mem_wdata = 32'h0000_0BAD;
    bus_if.mem_wstrb = 4'hF;
    @(posedge clk);
    #1;
    check("abort write in resp", {31'h0, bus_if.mem_ready}, (WR_LAT == 1) ? 32'h1 : 32'h0);
    reset = 1'b1;
    #1;
    check("abort write ready cleared", {31'h0, bus_if.mem_ready}, 32'h0);
    bus_if.mem_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    check("abort write rdata reset", bus_if.mem_rdata, 32'h0);
    check_cnts("abort write");

    // Reset abort of a read while BUSY.
    bus_if.mem_valid = 1'b1;
    bus_if.mem_addr  = 32'h20;
    bus_if.mem_wstrb = 4'h0;
    @(posedge clk);
    #1;
    check("abort read busy no ready", {31'h0, bus_if.mem_ready}, 32'h0);
    reset = 1'b1;
    bus_if.mem_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("abort read no pulse", {31'h0, bus_if.mem_ready}, 32'h0);
    end
    check_cnts("abort read");

    xfer(32'h20, 32'h0, 4'h0, 1'b0, got, lat);
    model_apply(32'h20, 32'h0, 4'h0, exp);
    check("after abort latency", 32'(lat), 32'(RD_LAT));
    check("after abort rdata", got, 32'h1);
    check("after abort model", got, exp);
    check_cnts("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
